// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment constants shared by the seven-segment scan controller
package seg7_pkg;

  // Active-low a..g in bits 0..6, dp in bit 7 (kept high = dp off).
  localparam logic [7:0] SEG_HEX_0 = 8'hC0;
  localparam logic [7:0] SEG_HEX_1 = 8'hF9;
  localparam logic [7:0] SEG_HEX_2 = 8'hA4;
  localparam logic [7:0] SEG_HEX_3 = 8'hB0;
  localparam logic [7:0] SEG_HEX_4 = 8'h99;
  localparam logic [7:0] SEG_HEX_5 = 8'h92;
  localparam logic [7:0] SEG_HEX_6 = 8'h82;
  localparam logic [7:0] SEG_HEX_7 = 8'hF8;
  localparam logic [7:0] SEG_HEX_8 = 8'h80;
  localparam logic [7:0] SEG_HEX_9 = 8'h90;
  localparam logic [7:0] SEG_HEX_A = 8'h88;
  localparam logic [7:0] SEG_HEX_B = 8'h83;
  localparam logic [7:0] SEG_HEX_C = 8'hC6;
  localparam logic [7:0] SEG_HEX_D = 8'hA1;
  localparam logic [7:0] SEG_HEX_E = 8'h86;
  localparam logic [7:0] SEG_HEX_F = 8'h8E;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam int         SEG_DP_BIT = 7;

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to active-low a..g pattern
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK[6:0];
    case (nibble)
      4'h0: pattern = SEG_HEX_0[6:0];
      4'h1: pattern = SEG_HEX_1[6:0];
      4'h2: pattern = SEG_HEX_2[6:0];
      4'h3: pattern = SEG_HEX_3[6:0];
      4'h4: pattern = SEG_HEX_4[6:0];
      4'h5: pattern = SEG_HEX_5[6:0];
      4'h6: pattern = SEG_HEX_6[6:0];
      4'h7: pattern = SEG_HEX_7[6:0];
      4'h8: pattern = SEG_HEX_8[6:0];
      4'h9: pattern = SEG_HEX_9[6:0];
      4'hA: pattern = SEG_HEX_A[6:0];
      4'hB: pattern = SEG_HEX_B[6:0];
      4'hC: pattern = SEG_HEX_C[6:0];
      4'hD: pattern = SEG_HEX_D[6:0];
      4'hE: pattern = SEG_HEX_E[6:0];
      4'hF: pattern = SEG_HEX_F[6:0];
      default: pattern = SEG_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - time-multiplexed seven-segment scan with PWM, blanking and zero suppression
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 625,
  parameter int PWM_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lz_en,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [DIGITS-1:0]     AN,
  output logic [7:0]            SEG,
  output logic                  frame_done
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);

  logic [DIV_W-1:0]    div_q, div_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [DIG_W-1:0]    dig_q, dig_d, dig_next, seg_dig;
  logic                first_q, first_d;
  logic [4*DIGITS-1:0] sh_data_q, sh_data_d, src_data;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, src_dp;
  logic [DIGITS-1:0]   sh_blank_q, sh_blank_d, src_blank;
  logic                sh_lz_q, sh_lz_d, src_lz;
  logic [PWM_BITS-1:0] sh_bright_q, sh_bright_d;
  logic [DIGITS-1:0]   an_q, an_d, supp;
  logic [7:0]          seg_q, seg_d;
  logic                frame_done_q, frame_done_d;
  logic                step, wrap, boundary, load, zero_run;
  logic [3:0]          sel_nib;
  logic                sel_dp, sel_blank, sel_supp;
  logic [6:0]          dec_pat;

  always_comb begin
    step     = (div_q == DIV_LAST);
    wrap     = step && (pwm_q == '1);
    boundary = wrap && (dig_q == DIG_LAST);
    div_d    = step ? '0 : div_q + 1'b1;
    pwm_d    = step ? pwm_q + 1'b1 : pwm_q;
    dig_next = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
    dig_d    = wrap ? dig_next : dig_q;
    first_d  = 1'b0;

    load        = first_q || boundary;
    sh_data_d   = load ? data       : sh_data_q;
    sh_dp_d     = load ? dp_mask    : sh_dp_q;
    sh_blank_d  = load ? blank_mask : sh_blank_q;
    sh_lz_d     = load ? lz_en      : sh_lz_q;
    sh_bright_d = load ? brightness : sh_bright_q;
    frame_done_d = boundary && !first_q;

    // SEG switches one cycle early, in the always-dark last PWM step, giving the dead time
    seg_dig   = wrap ? dig_next : dig_q;
    src_data  = boundary ? data       : sh_data_q;
    src_dp    = boundary ? dp_mask    : sh_dp_q;
    src_blank = boundary ? blank_mask : sh_blank_q;
    src_lz    = boundary ? lz_en      : sh_lz_q;

    zero_run = 1'b1;
    supp     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (src_data[4*i +: 4] == 4'h0);
      supp[i]  = src_lz && zero_run && (i > 0);
    end

    sel_nib   = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    sel_supp  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (seg_dig == DIG_W'(i)) begin
        sel_nib   = src_data[4*i +: 4];
        sel_dp    = src_dp[i];
        sel_blank = src_blank[i];
        sel_supp  = supp[i];
      end
    end

    for (int i = 0; i < DIGITS; i++) begin
      an_d[i] = !((sh_bright_q > pwm_q) && (dig_q == DIG_W'(i)));
    end
  end

  seg7_hex_decode u_dec (
    .nibble  (sel_nib),
    .pattern (dec_pat)
  );

  always_comb begin
    seg_d = SEG_BLANK;
    if (!sel_blank) begin
      if (!sel_supp) seg_d[6:0] = dec_pat;
      seg_d[SEG_DP_BIT] = ~sel_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q        <= '0;
      pwm_q        <= '0;
      dig_q        <= '0;
      first_q      <= 1'b1;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      sh_lz_q      <= 1'b0;
      sh_bright_q  <= '0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      pwm_q        <= pwm_d;
      dig_q        <= dig_d;
      first_q      <= first_d;
      sh_data_q    <= sh_data_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      sh_lz_q      <= sh_lz_d;
      sh_bright_q  <= sh_bright_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign AN         = an_q;
  assign SEG        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed bench for seg7_scan_ctrl (4 digits, 8-cycle slots, 32-cycle frames)
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp_mask;
  logic [3:0]  blank_mask;
  logic        lz_en;
  logic [1:0]  brightness;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.DIGITS(4), .SCAN_DIV(2), .PWM_BITS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .lz_en      (lz_en),
    .brightness (brightness),
    .AN         (an),
    .SEG        (seg),
    .frame_done (frame_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Holds reset for 3 edges, releases, and stops in the first cycle after release.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_an", an, 4'hF);
      check_eq("rst_seg", seg, 8'hFF);
      check_eq("rst_fd", frame_done, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    check_eq("first_an", an, 4'hF);
    check_eq("first_fd", frame_done, 1'b0);
  endtask

  // Cycle idx of a frame: slot d = idx/8, offset o = idx%8; lit for 2*bright steps,
  // last cycle of each slot is dark and already shows the next digit.
  task automatic scan(input string tag, input int first, input int last,
                      input logic [31:0] segs, input logic [7:0] next0, input int bright);
    for (int idx = first; idx <= last; idx++) begin
      int d;
      int o;
      logic [3:0] ea;
      logic [7:0] es;
      @(negedge clk);
      d  = idx / 8;
      o  = idx % 8;
      ea = (o < 2 * bright) ? ~(4'b0001 << d) : 4'hF;
      if (o == 7) es = (d == 3) ? next0 : segs[8*(d+1) +: 8];
      else        es = segs[8*d +: 8];
      check_eq({tag, "_an"}, an, ea);
      check_eq({tag, "_seg"}, seg, es);
      check_eq({tag, "_fd"}, frame_done, (idx == 31) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    rst = 1'b0; data = 16'hFFFF; dp_mask = 4'hF; blank_mask = 4'h0;
    lz_en = 1'b1; brightness = 2'd3;
    do_reset();

    data = 16'h3210; dp_mask = 4'h0; lz_en = 1'b0; brightness = 2'd3;
    do_reset();
    scan("scan_f0", 1, 31, 32'hB0A4F9C0, 8'hC0, 3);
    scan("scan_f1", 0, 31, 32'hB0A4F9C0, 8'hC0, 3);

    brightness = 2'd1;
    do_reset();
    scan("pwm1", 1, 31, 32'hB0A4F9C0, 8'hC0, 1);
    brightness = 2'd0;
    do_reset();
    scan("pwm0_f0", 1, 31, 32'hB0A4F9C0, 8'hC0, 0);
    scan("pwm0_f1", 0, 31, 32'hB0A4F9C0, 8'hC0, 0);

    data = 16'h0050; lz_en = 1'b1; dp_mask = 4'b1000; brightness = 2'd3;
    do_reset();
    scan("lz_on", 1, 31, 32'h7FFF92C0, 8'hC0, 3);
    lz_en = 1'b0;
    do_reset();
    scan("lz_off", 1, 31, 32'h40C092C0, 8'hC0, 3);

    data = 16'h1111; lz_en = 1'b0; dp_mask = 4'h0;
    do_reset();
    scan("sh_f0", 1, 31, 32'hF9F9F9F9, 8'hF9, 3);
    scan("sh_f1a", 0, 15, 32'hF9F9F9F9, 8'hF9, 3);
    data = 16'h2222;
    scan("sh_f1b", 16, 31, 32'hF9F9F9F9, 8'hA4, 3);
    scan("sh_f2", 0, 31, 32'hA4A4A4A4, 8'hA4, 3);

    data = 16'h3210; blank_mask = 4'b0010;
    do_reset();
    scan("blank_f0", 1, 31, 32'hB0A4FFC0, 8'hC0, 3);
    scan("blank_f1", 0, 12, 32'hB0A4FFC0, 8'hC0, 3);
    do_reset();
    scan("after_rst", 1, 31, 32'hB0A4FFC0, 8'hC0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised seven-segment scan controller: time-multiplexes `DIGITS` hex digits onto a shared active-low segment bus, driving one active-low anode at a time. It adds per-digit decimal points, blanking, leading-zero suppression and PWM brightness. Inputs are captured into shadow registers once per frame, so a display update never tears mid-frame. It sits between the CPU's LED data register and the board pins. It replaces the free-running anode counter and the separately derived LED clock with a single-clock, clock-enable design.

## Interface
- `DIGITS`, 8: number of digits/anodes, ≥1.
- `SCAN_DIV`, 625: clk cycles per PWM step, ≥1. Digit slot = `SCAN_DIV`·2^`PWM_BITS` cycles.
- `PWM_BITS`, 4: brightness resolution, ≥1.

- `clk` in 1: system clock; only clock.
- `rst` in 1: reset, synchronous, active-low.
- `data` in 4·DIGITS: hex nibbles; digit i = `data[4i+3:4i]`.
- `dp_mask` in DIGITS: 1 = decimal point on for digit i.
- `blank_mask` in DIGITS: 1 = digit i fully dark (segments and dp).
- `lz_en` in 1: enable leading-zero suppression.
- `brightness` in PWM_BITS: on-duty in PWM steps; 0 = dark.
- `AN` out DIGITS: anodes, active-low, at most one low.
- `SEG` out 8: bits 0–6 = a–g, bit 7 = dp; active-low.
- `frame_done` out 1: one-cycle pulse at each frame boundary.

## Operation
- Counters:
  - `div_cnt` runs 0..SCAN_DIV-1. `step` asserts when `div_cnt`==SCAN_DIV-1.
  - On `step`, `pwm_cnt` (PWM_BITS wide) increments with natural wrap.
  - When `pwm_cnt` wraps on `step`, `dig_idx` advances 0→1→…→DIGITS-1→0.
- Frame boundary: a `step` where `pwm_cnt` wraps and `dig_idx`==DIGITS-1. That cycle:
  - shadow ← {`data`, `dp_mask`, `blank_mask`, `lz_en`, `brightness`};
  - `frame_done` pulses.
- First cycle with `rst`=1 after reset:
  - shadow loads unconditionally;
  - `frame_done` is not pulsed.
- Input changes at any other time are invisible until the next boundary.
- Leading-zero suppression (shadow `lz_en`=1):
  - Digit i is suppressed iff i>0 and the shadow nibbles for all j≥i are 0.
  - Digit 0 is never suppressed.
  - Suppressed digits keep their dp if `dp_mask` is set.
- Per-slot pattern:
  - blank → 8'hFF;
  - otherwise hex decode of the nibble, with bit 7 cleared if dp is set;
  - suppressed → 8'hFF except the dp bit.
- Anode drive:
  - `AN[dig_idx]`=0 iff shadow brightness > `pwm_cnt`; otherwise all AN=1.
  - A blanked digit still drives its anode; only SEG is 8'hFF.
- Decode values (no dp): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.

## Timing
- `AN`, `SEG` and `frame_done` are registered: each reflects the counter state of the previous cycle.
- Reset (`rst`=0 at a clk edge):
  - `div_cnt`, `pwm_cnt` and `dig_idx` = 0;
  - AN all ones, SEG=8'hFF, frame_done=0;
  - shadow: data 0, masks 0, brightness 0.
- Reset asserted mid-frame: on the next edge the outputs go dark and counters restart at 0. No partial-frame carry-over.
- First lit output: the second cycle after reset release, if the sampled brightness > 0.
- Digit order: index 0 first, then ascending.
- Slot length is exactly `SCAN_DIV`·2^`PWM_BITS` cycles. `frame_done` period is exactly DIGITS times that.
- Dead time: on a `dig_idx` change, AN goes all ones for the one cycle in which SEG changes, then the new anode asserts. This applies whenever brightness>0 and prevents ghosting.
- Parameter edge cases: `SCAN_DIV`=1 means `step` every cycle. `DIGITS`=1 means every slot boundary is a frame boundary.

## Structure
- Package/header `seg7_pkg`: the 16 segment constants, `SEG_BLANK`=8'hFF and the dp bit index.
- Sub-module `seg7_hex_decode`: combinational nibble → 7-bit pattern.
- Top level holds the counters, shadow registers, the suppression chain (scan from MSB) and the output registers.

## Test plan
Bench parameters: DIGITS=4, SCAN_DIV=2, PWM_BITS=2 (slot 8 cycles, frame 32 cycles).

- Reset: hold `rst`=0 for 3 cycles with all inputs active → AN=4'hF, SEG=8'hFF, frame_done=0 throughout.
- Scan: data=16'h3210, brightness=3 → AN walks E,D,B,7 each for 6 lit cycles per 8-cycle slot, with SEG=C0,F9,A4,B0 respectively. `frame_done` period is 32 cycles.
- PWM: brightness=1 → anode low for 2 of 8 cycles per slot; brightness=0 → AN stays F indefinitely.
- Leading-zero suppression: data=16'h0050, lz_en=1, dp_mask=4'b1000 → digit 3 SEG=7F, digit 2 SEG=FF, digit 1 SEG=92, digit 0 SEG=C0. With lz_en=0 → digit 2 shows C0.
- Shadow: change data from 16'h1111 to 16'h2222 mid-frame → remaining slots still show F9; the next frame shows A4.
- Blank and dead time: blank_mask=4'b0010 → digit 1 slot has SEG=FF with its anode still low; one all-ones AN cycle appears at every slot change.
